tlc_request_ctrl: RTL and testbench

//  Front-end sequencer for the traffic-light FSM. Owns the cycle counter (Count) that the FSM

---
 rtl/tlc_request_ctrl_if.sv | 44 ++++
 rtl/tlc_request_ctrl.sv | 158 +++++++++++++++
 tb/tb_tlc_request_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/tlc_request_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : tlc_request_ctrl_if
//  Brief    : Bundle between the traffic-light FSM side and the request
//             front-end. Carries the counter, sensor and debug signals.
//             The pedestrian pair exists only when TLC_PED_REQUEST_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
interface tlc_request_ctrl_if #(
    parameter int COUNT_W = 31
);
    logic               RstCount;
    logic [2:0]         fsmState;
    logic               farmRaw;
    logic [COUNT_W-1:0] Count;
    logic               farmSensor;
    logic               farmFiltered;
    logic [1:0]         reqState;
`ifdef TLC_PED_REQUEST_EN
    logic               pedButton;
    logic               pedWalk;
`endif

    // FSM side: drives the controls, observes the results
    modport master (
        output RstCount, fsmState, farmRaw,
`ifdef TLC_PED_REQUEST_EN
        output pedButton,
        input  pedWalk,
`endif
        input  Count, farmSensor, farmFiltered, reqState
    );

    // Request front-end side
    modport slave (
        input  RstCount, fsmState, farmRaw,
`ifdef TLC_PED_REQUEST_EN
        input  pedButton,
        output pedWalk,
`endif
        output Count, farmSensor, farmFiltered, reqState
    );
endinterface
`default_nettype wire

// File: rtl/tlc_request_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tlc_request_ctrl
//  Brief    : Front-end sequencer for the traffic-light FSM: saturating cycle
//             counter, farm sensor synchroniser + debouncer, and a request
//             latch that turns a short car pulse into a farm-green request.
//             Optional macro TLC_PED_REQUEST_EN adds a pedestrian button.
//  Revision : 1.0  initial release
// ============================================================================
module tlc_request_ctrl #(
    parameter int COUNT_W         = 31,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_W            = 20
) (
    input  logic                  Clk,
    input  logic                  Rst,
    tlc_request_ctrl_if.slave     bus
);

    // Debounce states; bit 1 doubles as the filtered level
    localparam logic [1:0] c_DB_STABLE_LO = 2'b00;
    localparam logic [1:0] c_DB_ARM_HI    = 2'b01;
    localparam logic [1:0] c_DB_STABLE_HI = 2'b10;
    localparam logic [1:0] c_DB_ARM_LO    = 2'b11;

    // Request states
    localparam logic [1:0] c_REQ_NO      = 2'b00;
    localparam logic [1:0] c_REQ_PENDING = 2'b01;
    localparam logic [1:0] c_REQ_SERVING = 2'b10;

    // Traffic FSM states of interest
    localparam logic [2:0] c_S0 = 3'b000;
    localparam logic [2:0] c_S1 = 3'b001;
    localparam logic [2:0] c_S4 = 3'b100;

    localparam logic [DB_W-1:0]    c_DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DB_W-1:0]    c_DB_ONE    = DB_W'(1);
    localparam logic [COUNT_W-1:0] c_COUNT_MAX = '1;

    logic [COUNT_W-1:0] count_q;
    logic               sync1_q, sync2_q;
    logic [1:0]         db_q, db_d;
    logic [DB_W-1:0]    dbc_q, dbc_d;
    logic [1:0]         req_q, req_d;
    logic               farm_sensor_q, farm_sensor_d;
    logic               filtered;
    logic               ped_rise;

    assign filtered = db_q[1];

    // Saturating cycle counter; a clear always wins over saturation
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst)                     count_q <= '0;
        else if (bus.RstCount)       count_q <= '0;
        else if (count_q != c_COUNT_MAX) count_q <= count_q + 1'b1;
    end

    // Two-flop synchroniser on the asynchronous farm sensor
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= bus.farmRaw;
            sync2_q <= sync1_q;
        end
    end

`ifdef TLC_PED_REQUEST_EN
    logic ped1_q, ped2_q, ped3_q;

    // Synchronise the button and keep one extra stage for rise detection
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            ped1_q <= 1'b0;
            ped2_q <= 1'b0;
            ped3_q <= 1'b0;
        end else begin
            ped1_q <= bus.pedButton;
            ped2_q <= ped1_q;
            ped3_q <= ped2_q;
        end
    end

    assign ped_rise    = ped2_q & ~ped3_q;
    assign bus.pedWalk = (req_q == c_REQ_SERVING) && (bus.fsmState == c_S4);
`else
    assign ped_rise = 1'b0;
`endif

    // Debounce next state: a new level must persist DEBOUNCE_CYCLES samples
    always_comb begin
        db_d  = db_q;
        dbc_d = dbc_q;
        case (db_q)
            c_DB_STABLE_LO: if (sync2_q) begin
                db_d  = c_DB_ARM_HI;
                dbc_d = c_DB_ONE;
            end
            c_DB_ARM_HI: begin
                if (!sync2_q)                db_d  = c_DB_STABLE_LO;
                else if (dbc_q == c_DB_LAST) db_d  = c_DB_STABLE_HI;
                else                         dbc_d = dbc_q + 1'b1;
            end
            c_DB_STABLE_HI: if (!sync2_q) begin
                db_d  = c_DB_ARM_LO;
                dbc_d = c_DB_ONE;
            end
            default: begin
                if (sync2_q)                 db_d  = c_DB_STABLE_HI;
                else if (dbc_q == c_DB_LAST) db_d  = c_DB_STABLE_LO;
                else                         dbc_d = dbc_q + 1'b1;
            end
        endcase
    end

    // Request latch: armed only in S1 (or by the ped button), served in S4,
    // released when the FSM returns to S0
    always_comb begin
        req_d = req_q;
        case (req_q)
            c_REQ_NO:      if ((filtered && (bus.fsmState == c_S1)) || ped_rise)
                               req_d = c_REQ_PENDING;
            c_REQ_PENDING: if (bus.fsmState == c_S4) req_d = c_REQ_SERVING;
            c_REQ_SERVING: if (bus.fsmState == c_S0) req_d = c_REQ_NO;
            default:       req_d = c_REQ_NO;
        endcase
    end

    // While serving, pass the live level so the FSM can end farm green early
    always_comb begin
        farm_sensor_d = 1'b0;
        if (req_q == c_REQ_PENDING)      farm_sensor_d = 1'b1;
        else if (req_q == c_REQ_SERVING) farm_sensor_d = filtered;
    end

    // State registers for debounce, request and sensor output
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            db_q          <= c_DB_STABLE_LO;
            dbc_q         <= '0;
            req_q         <= c_REQ_NO;
            farm_sensor_q <= 1'b0;
        end else begin
            db_q          <= db_d;
            dbc_q         <= dbc_d;
            req_q         <= req_d;
            farm_sensor_q <= farm_sensor_d;
        end
    end

    assign bus.Count        = count_q;
    assign bus.farmFiltered = filtered;
    assign bus.reqState     = req_q;
    assign bus.farmSensor   = farm_sensor_q;

endmodule
`default_nettype wire

// File: tb/tb_tlc_request_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tlc_request_ctrl
//  Brief    : Directed self-checking bench for tlc_request_ctrl
//             (small counter width and short debounce for quick runs).
//  Revision : 1.0  initial release
// ============================================================================
module tb_tlc_request_ctrl;

    localparam int c_COUNT_W = 12;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    tlc_request_ctrl_if #(.COUNT_W(c_COUNT_W)) bus ();

    tlc_request_ctrl #(
        .COUNT_W         (c_COUNT_W),
        .DEBOUNCE_CYCLES (4),
        .DB_W            (3)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.RstCount = 1'b0;
        bus.fsmState = 3'd0;
        bus.farmRaw  = 1'b0;
`ifdef TLC_PED_REQUEST_EN
        bus.pedButton = 1'b0;
`endif
        #12;
        chk("reset_count",    32'(bus.Count), 32'd0);
        chk("reset_req",      32'(bus.reqState), 32'd0);
        chk("reset_sensor",   32'(bus.farmSensor), 32'd0);
        chk("reset_filtered", 32'(bus.farmFiltered), 32'd0);

        // 1. Counter
        @(posedge Clk); #1; Rst = 1'b0;
        repeat (10) tick();
        chk("count_10", 32'(bus.Count), 32'd10);
        bus.RstCount = 1'b1; tick();
        chk("count_clear", 32'(bus.Count), 32'd0);
        bus.RstCount = 1'b0; tick();
        chk("count_resume", 32'(bus.Count), 32'd1);
        repeat (4100) tick();
        chk("count_saturate", 32'(bus.Count), 32'hFFF);
        tick();
        chk("count_hold", 32'(bus.Count), 32'hFFF);
        bus.RstCount = 1'b1; tick();
        chk("count_clear_sat", 32'(bus.Count), 32'd0);
        bus.RstCount = 1'b0;

        // 2. Glitch of 3 cycles, even in S1, is rejected
        bus.fsmState = 3'd1;
        bus.farmRaw = 1'b1; repeat (3) tick();
        bus.farmRaw = 1'b0; repeat (8) tick();
        chk("glitch_filtered", 32'(bus.farmFiltered), 32'd0);
        chk("glitch_req",      32'(bus.reqState), 32'd0);

        // 3. Accept with S1
        bus.farmRaw = 1'b1;
        repeat (5) tick();
        chk("accept_c5_filtered", 32'(bus.farmFiltered), 32'd0);
        tick();
        chk("accept_c6_filtered", 32'(bus.farmFiltered), 32'd1);
        chk("accept_c6_req",      32'(bus.reqState), 32'd0);
        tick();
        chk("accept_c7_req",      32'(bus.reqState), 32'd1);
        chk("accept_c7_sensor",   32'(bus.farmSensor), 32'd0);
        tick();
        chk("accept_c8_sensor",   32'(bus.farmSensor), 32'd1);

        // 4. Short car: request survives the sensor falling
        bus.farmRaw = 1'b0; bus.fsmState = 3'd2;
        repeat (8) tick();
        chk("short_filtered_low", 32'(bus.farmFiltered), 32'd0);
        chk("short_req_held",     32'(bus.reqState), 32'd1);
        chk("short_sensor_held",  32'(bus.farmSensor), 32'd1);
        bus.fsmState = 3'd4; tick();
        chk("serve_req", 32'(bus.reqState), 32'd2);
        tick();
        chk("serve_sensor_follow", 32'(bus.farmSensor), 32'd0);
        bus.fsmState = 3'd0; tick();
        chk("release_req", 32'(bus.reqState), 32'd0);

        // Rise outside S1 is not latched until S1 comes round
        bus.fsmState = 3'd2; bus.farmRaw = 1'b1;
        repeat (8) tick();
        chk("rise_s2_filtered", 32'(bus.farmFiltered), 32'd1);
        chk("rise_s2_no_latch", 32'(bus.reqState), 32'd0);
        bus.fsmState = 3'd1; tick();
        chk("rise_later_s1", 32'(bus.reqState), 32'd1);
        bus.fsmState = 3'd4; tick();
        tick();
        chk("serve_sensor_high", 32'(bus.farmSensor), 32'd1);
        bus.fsmState = 3'd0; bus.farmRaw = 1'b0;
        repeat (8) tick();

        // 5. Asynchronous reset while PENDING at Count=1234
        bus.RstCount = 1'b1; tick();
        bus.RstCount = 1'b0; bus.fsmState = 3'd1; bus.farmRaw = 1'b1;
        repeat (1234) tick();
        chk("pre_rst_count", 32'(bus.Count), 32'd1234);
        chk("pre_rst_req",   32'(bus.reqState), 32'd1);
        #2; Rst = 1'b1; #1;
        chk("async_count",    32'(bus.Count), 32'd0);
        chk("async_sensor",   32'(bus.farmSensor), 32'd0);
        chk("async_filtered", 32'(bus.farmFiltered), 32'd0);
        chk("async_req",      32'(bus.reqState), 32'd0);
        bus.farmRaw = 1'b0; bus.fsmState = 3'd0;
        tick();
        Rst = 1'b0;
        repeat (3) tick();

`ifdef TLC_PED_REQUEST_EN
        // 6. Pedestrian request in S0
        bus.pedButton = 1'b1; repeat (2) tick();
        bus.pedButton = 1'b0; repeat (2) tick();
        chk("ped_req", 32'(bus.reqState), 32'd1);
        chk("ped_walk_idle", 32'(bus.pedWalk), 32'd0);
        bus.fsmState = 3'd4; tick();
        chk("ped_walk_on", 32'(bus.pedWalk), 32'd1);
        bus.fsmState = 3'd5; #1;
        chk("ped_walk_off", 32'(bus.pedWalk), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
